// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply,
// restoring divide, plus mthi/mtlo moves. Fixed WIDTH+1 cycle latency.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned DW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt;
   logic            is_mul;
   logic            neg_q;    // sign(a) != sign(b) on a signed op
   logic            neg_r;    // dividend negative on a signed op
   logic            dz;       // divide with zero divisor
   logic [WIDTH-1:0] opnd;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0] a_raw;   // original dividend, returned in HI on divide-by-zero
   logic [DW-1:0]   acc;      // product accumulator; low half is dividend/quotient
   logic [WIDTH-1:0] rem;

   logic             is_signed_c, sa_c, sb_c;
   logic [WIDTH-1:0] a_abs_c, b_abs_c;
   logic [WIDTH:0]   sum_c, shifted_c, diff_c;
   logic             ge_c;
   logic [DW-1:0]    prod_c;
   logic [WIDTH-1:0] quo_c, rmd_c;

   // Operand magnitudes, one iteration of each algorithm and the sign fix-up
   always_comb begin
      is_signed_c = ~md_op[0];
      sa_c        = is_signed_c & src_a[WIDTH-1];
      sb_c        = is_signed_c & src_b[WIDTH-1];
      a_abs_c     = sa_c ? WIDTH'(-src_a) : src_a;
      b_abs_c     = sb_c ? WIDTH'(-src_b) : src_b;
      sum_c       = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
      shifted_c   = {rem, acc[WIDTH-1]};
      diff_c      = shifted_c - {1'b0, opnd};
      ge_c        = ~diff_c[WIDTH];
      prod_c      = neg_q ? DW'(-acc) : acc;
      quo_c       = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      rmd_c       = neg_r ? WIDTH'(-rem) : rem;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start && !md_op[2]) state_next = CALC;
         CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath, HI/LO and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         is_mul      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz          <= 1'b0;
         opnd        <= '0;
         a_raw       <= '0;
         acc         <= '0;
         rem         <= '0;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  if (!md_op[2]) begin
                     is_mul      <= ~md_op[1];
                     cnt         <= '0;
                     acc         <= {WIDTH'(0), md_op[1] ? a_abs_c : b_abs_c};
                     opnd        <= md_op[1] ? b_abs_c : a_abs_c;
                     rem         <= '0;
                     a_raw       <= src_a;
                     neg_q       <= sa_c ^ sb_c;
                     neg_r       <= sa_c;
                     dz          <= md_op[1] && (src_b == '0);
                     div_by_zero <= 1'b0;
                  end else if (md_op[1:0] == 2'b00) begin
                     hi          <= src_a;
                     div_by_zero <= 1'b0;
                  end else if (md_op[1:0] == 2'b01) begin
                     lo          <= src_a;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (is_mul) begin
                  acc <= {sum_c, acc[WIDTH-1:1]};
               end else begin
                  rem <= ge_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
                  acc <= {acc[DW-1:WIDTH], acc[WIDTH-2:0], ge_c};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (is_mul) begin
                  hi <= prod_c[DW-1:WIDTH];
                  lo <= prod_c[WIDTH-1:0];
               end else if (dz) begin
                  hi          <= a_raw;
                  lo          <= '1;
                  div_by_zero <= 1'b1;
               end else begin
                  hi <= rmd_c;
                  lo <= quo_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: mult/div variants, divide-by-zero,
// back-to-back issue, moves, stall behaviour and asynchronous reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic [31:0] hi, lo;
   logic        busy, done, div_by_zero;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Issue a mult/div at the current negedge; returns at the negedge of the done cycle
   task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz);
      int  cycles;
      bit  ended;
      cycles = 0;
      ended  = 0;
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      src_a = $urandom; src_b = $urandom;
      check({tag, " dz_clr"}, 32'(div_by_zero), 32'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin
            ended = 1;
            break;
         end
         cycles++;
         if (i == 10) begin
            check({tag, " hold_hi"}, hi, last_hi);
            check({tag, " hold_lo"}, lo, last_lo);
         end
      end
      check({tag, " busy_cyc"}, 32'(cycles), 32'd33);
      check({tag, " ended"}, 32'(ended), 32'd1);
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
      check({tag, " dz"}, 32'(div_by_zero), 32'(exp_dz));
      last_hi = exp_hi;
      last_lo = exp_lo;
   endtask

   // mthi/mtlo issued at the current negedge; returns at the next negedge
   task automatic mv(input string tag, input logic [2:0] op, input logic [31:0] a);
      start = 1'b1; md_op = op; src_a = a; src_b = '0;
      @(posedge clk); #1;
      start = 1'b0;
      if (op == 3'd4) last_hi = a;
      else            last_lo = a;
      check({tag, " hi"}, hi, last_hi);
      check({tag, " lo"}, lo, last_lo);
      check({tag, " busy"}, 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int cycles;
      rst_n = 1'b0; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
      repeat (3) @(negedge clk);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst dz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_md("mult",  3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      @(negedge clk);
      check("done_fall", 32'(done), 32'd0);
      run_md("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      run_md("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_md("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_md("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
      run_md("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
      run_md("div_m5_0", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
      run_md("divu_5_0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
      run_md("mult_3_3", 3'd0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);
      run_md("multu_big", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0);

      mv("mthi", 3'd4, 32'h1234);
      mv("mtlo", 3'd5, 32'h5678);

      // mtlo held during a busy mult must be ignored
      start = 1'b1; md_op = 3'd0; src_a = 32'd5; src_b = 32'd6;
      @(posedge clk); #1;
      md_op = 3'd5; src_a = 32'hDEAD;
      repeat (5) @(negedge clk);
      check("stall lo_hold", lo, 32'h5678);
      start = 1'b0;
      cycles = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         cycles++;
      end
      check("stall busy_cyc", 32'(cycles + 5), 32'd33);
      check("stall done", 32'(done), 32'd1);
      check("stall hi", hi, 32'd0);
      check("stall lo", lo, 32'd30);
      @(negedge clk);
      check("stall lo_after", lo, 32'd30);

      // asynchronous reset in the middle of a mult
      start = 1'b1; md_op = 3'd0; src_a = 32'hFFFFFFFF; src_b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst hi", hi, 32'd0);
      check("arst lo", lo, 32'd0);
      check("arst busy", 32'(busy), 32'd0);
      check("arst done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      last_hi = '0;
      last_lo = '0;
      run_md("divu_9_3", 3'd3, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
